// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/flush controller for a 5-stage pipeline: redirect flush, load-use and MDU stalls, perf counters.
// Latency: control outputs are combinational from inputs and registered state; counters update next cycle.
// Backpressure: stalls freeze PC/IF/ID (and ID/EX for MDU); a redirect flushes and holds IF/ID for FLUSH_HOLD cycles.
module pipeline_hazard_ctrl #(
  parameter int NUM_FLUSH  = 2,
  parameter int FLUSH_HOLD = 1,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  branch_taken_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic                  id_rs1_used_i,
  input  logic                  id_rs2_used_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic                  ex_mem_read_i,
  input  logic                  mdu_busy_i,
  output logic                  pc_en_o,
  output logic                  ifid_en_o,
  output logic                  idex_en_o,
  output logic [NUM_FLUSH-1:0]  flush_vec_o,
  output logic                  stall_o,
  output logic [CNT_W-1:0]      redirect_cnt_o,
  output logic [CNT_W-1:0]      stall_cnt_o
);

  localparam int HL_W = $clog2(FLUSH_HOLD + 1);
  localparam logic [HL_W-1:0]      HOLD_RELOAD = HL_W'(FLUSH_HOLD - 1);
  localparam logic [NUM_FLUSH-1:0] FLUSH_IFID  = NUM_FLUSH'(1);
  localparam logic [NUM_FLUSH-1:0] FLUSH_IDEX  = NUM_FLUSH'(2);

  typedef enum logic [0:0] {
    S_RUN  = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [HL_W-1:0] hold_left_q, hold_left_d;
  logic [CNT_W-1:0] redirect_cnt_q, stall_cnt_q;
  logic            redirect_inc, stall_inc;
  logic            load_use;

  // Load-use: the EX load writes a register the ID instruction actually reads (x0 never hazards).
  always_comb begin
    load_use = ex_mem_read_i && (ex_rd_i != '0) &&
               ((id_rs1_used_i && (id_rs1_i == ex_rd_i)) ||
                (id_rs2_used_i && (id_rs2_i == ex_rd_i)));
  end

  // State register: RUN/HOLD and the remaining IF/ID flush cycles.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_RUN;
      hold_left_q <= '0;
    end else begin
      state_q     <= state_d;
      hold_left_q <= hold_left_d;
    end
  end

  // Priority decision: reset > redirect > hold > MDU > load-use > normal flow.
  always_comb begin
    state_d      = state_q;
    hold_left_d  = hold_left_q;
    pc_en_o      = 1'b1;
    ifid_en_o    = 1'b1;
    idex_en_o    = 1'b1;
    flush_vec_o  = '0;
    stall_o      = 1'b0;
    redirect_inc = 1'b0;
    stall_inc    = 1'b0;

    if (rst_i) begin
      flush_vec_o = '1;
      pc_en_o     = 1'b0;
      ifid_en_o   = 1'b0;
      idex_en_o   = 1'b0;
      state_d     = S_RUN;
      hold_left_d = '0;
    end else if (branch_taken_i) begin
      // A redirect in HOLD simply restarts the hold window.
      flush_vec_o  = '1;
      redirect_inc = 1'b1;
      if (FLUSH_HOLD > 1) begin
        state_d     = S_HOLD;
        hold_left_d = HOLD_RELOAD;
      end else begin
        state_d     = S_RUN;
        hold_left_d = '0;
      end
    end else if (state_q == S_HOLD) begin
      // ID holds a bubble here, so hazards are irrelevant; only IF/ID stays cleared.
      flush_vec_o = FLUSH_IFID;
      hold_left_d = hold_left_q - HL_W'(1);
      if (hold_left_q <= HL_W'(1)) begin
        state_d = S_RUN;
      end
    end else if (mdu_busy_i) begin
      pc_en_o   = 1'b0;
      ifid_en_o = 1'b0;
      idex_en_o = 1'b0;
      stall_o   = 1'b1;
      stall_inc = 1'b1;
    end else if (load_use) begin
      // Freeze the front end and push a bubble into ID/EX.
      pc_en_o     = 1'b0;
      ifid_en_o   = 1'b0;
      flush_vec_o = FLUSH_IDEX;
      stall_o     = 1'b1;
      stall_inc   = 1'b1;
    end
  end

  // Saturating redirect and stall counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      redirect_cnt_q <= '0;
      stall_cnt_q    <= '0;
    end else begin
      if (redirect_inc && (redirect_cnt_q != '1)) begin
        redirect_cnt_q <= redirect_cnt_q + CNT_W'(1);
      end
      if (stall_inc && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end

  assign redirect_cnt_o = redirect_cnt_q;
  assign stall_cnt_o    = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two configurations driven with the same inputs.
// Instance A: NUM_FLUSH=2, FLUSH_HOLD=3, CNT_W=32. Instance B: NUM_FLUSH=3, FLUSH_HOLD=4, CNT_W=2.
// Directed scenarios use fixed expectations; the random scenario uses a cycle-level reference model.
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       br = 1'b0, rs1_used = 1'b0, rs2_used = 1'b0, mem_rd = 1'b0, mdu = 1'b0;
  logic [4:0] rs1 = '0, rs2 = '0, rd = '0;

  logic        a_pc, a_ifid, a_idex, a_stall;
  logic [1:0]  a_flush;
  logic [31:0] a_rc, a_sc;
  logic        b_pc, b_ifid, b_idex, b_stall;
  logic [2:0]  b_flush;
  logic [1:0]  b_rc, b_sc;

  pipeline_hazard_ctrl #(.NUM_FLUSH(2), .FLUSH_HOLD(3), .REG_ADDR_W(5), .CNT_W(32)) u_a (
    .clk_i(clk), .rst_i(rst), .branch_taken_i(br),
    .id_rs1_i(rs1), .id_rs2_i(rs2), .id_rs1_used_i(rs1_used), .id_rs2_used_i(rs2_used),
    .ex_rd_i(rd), .ex_mem_read_i(mem_rd), .mdu_busy_i(mdu),
    .pc_en_o(a_pc), .ifid_en_o(a_ifid), .idex_en_o(a_idex), .flush_vec_o(a_flush),
    .stall_o(a_stall), .redirect_cnt_o(a_rc), .stall_cnt_o(a_sc)
  );

  pipeline_hazard_ctrl #(.NUM_FLUSH(3), .FLUSH_HOLD(4), .REG_ADDR_W(5), .CNT_W(2)) u_b (
    .clk_i(clk), .rst_i(rst), .branch_taken_i(br),
    .id_rs1_i(rs1), .id_rs2_i(rs2), .id_rs1_used_i(rs1_used), .id_rs2_used_i(rs2_used),
    .ex_rd_i(rd), .ex_mem_read_i(mem_rd), .mdu_busy_i(mdu),
    .pc_en_o(b_pc), .ifid_en_o(b_ifid), .idex_en_o(b_idex), .flush_vec_o(b_flush),
    .stall_o(b_stall), .redirect_cnt_o(b_rc), .stall_cnt_o(b_sc)
  );

  // Observed control bundle: {pc_en, ifid_en, idex_en, stall, flush_vec zero-extended to 4}.
  wire [7:0] a_obs = {a_pc, a_ifid, a_idex, a_stall, 2'b00, a_flush};
  wire [7:0] b_obs = {b_pc, b_ifid, b_idex, b_stall, 1'b0, b_flush};

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state: remaining IF/ID-only flush cycles and counter values.
  int     m_hold [2];
  longint m_rc   [2];
  longint m_sc   [2];
  int     m_fh   [2] = '{3, 4};
  int     m_nf   [2] = '{2, 3};
  longint m_max  [2] = '{64'd4294967295, 64'd3};

  function automatic bit load_use_now();
    return mem_rd && (rd != 5'd0) &&
           ((rs1_used && (rs1 == rd)) || (rs2_used && (rs2 == rd)));
  endfunction

  function automatic logic [7:0] model_out(int idx);
    logic [3:0] ones;
    ones = 4'((1 << m_nf[idx]) - 1);
    if (rst)              return {4'b0000, ones};
    if (br)               return {4'b1110, ones};
    if (m_hold[idx] > 0)  return 8'b1110_0001;
    if (mdu)              return 8'b0001_0000;
    if (load_use_now())   return 8'b0011_0010;
    return 8'b1110_0000;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_hold[i] = 0; m_rc[i] = 0; m_sc[i] = 0;
      end else if (br) begin
        m_hold[i] = m_fh[i] - 1;
        if (m_rc[i] < m_max[i]) m_rc[i] = m_rc[i] + 1;
      end else if (m_hold[i] > 0) begin
        m_hold[i] = m_hold[i] - 1;
      end else if (mdu || load_use_now()) begin
        if (m_sc[i] < m_max[i]) m_sc[i] = m_sc[i] + 1;
      end
    end
  end

  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    br = 0; rs1_used = 0; rs2_used = 0; mem_rd = 0; mdu = 0; rs1 = 0; rs2 = 0; rd = 0;
  endtask

  task automatic apply_reset();
    rst = 1; clear_inputs();
    to_drive();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; clear_inputs();
    @(negedge clk);
    n_checks++; if (a_obs !== 8'b0000_0011) begin n_err++; $display("FAIL reset_ctrl_a obs=%b exp=%b", a_obs, 8'b0000_0011); end
    n_checks++; if (b_obs !== 8'b0000_0111) begin n_err++; $display("FAIL reset_ctrl_b obs=%b exp=%b", b_obs, 8'b0000_0111); end
    to_drive();
    @(negedge clk);
    n_checks++; if (a_rc !== 32'd0 || a_sc !== 32'd0) begin n_err++; $display("FAIL reset_cnt_a rc=%0d sc=%0d exp=0/0", a_rc, a_sc); end
    to_drive();
    rst = 0;
    @(negedge clk);
    n_checks++; if (a_obs !== 8'b1110_0000) begin n_err++; $display("FAIL reset_release obs=%b exp=%b", a_obs, 8'b1110_0000); end
    to_drive();
  endtask

  task automatic test_branch_hold();
    logic [7:0] exp_a [4] = '{8'b1110_0011, 8'b1110_0001, 8'b1110_0001, 8'b1110_0000};
    apply_reset();
    br = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_checks++; if (a_obs !== exp_a[k]) begin n_err++; $display("FAIL branch_hold_t%0d obs=%b exp=%b", k, a_obs, exp_a[k]); end
      if (k == 1) begin
        n_checks++; if (a_rc !== 32'd1) begin n_err++; $display("FAIL branch_rc obs=%0d exp=1", a_rc); end
      end
      to_drive();
      br = 0;
    end
  endtask

  task automatic test_load_use();
    apply_reset();
    mem_rd = 1; rd = 5; rs1 = 5; rs1_used = 1;
    @(negedge clk);
    n_checks++; if (a_obs !== 8'b0011_0010) begin n_err++; $display("FAIL lu_rs1 obs=%b exp=%b", a_obs, 8'b0011_0010); end
    to_drive();
    clear_inputs();
    @(negedge clk);
    n_checks++; if (a_sc !== 32'd1) begin n_err++; $display("FAIL lu_cnt obs=%0d exp=1", a_sc); end
    n_checks++; if (a_obs !== 8'b1110_0000) begin n_err++; $display("FAIL lu_release obs=%b exp=%b", a_obs, 8'b1110_0000); end
    to_drive();
    mem_rd = 1; rd = 0; rs1 = 0; rs1_used = 1;
    @(negedge clk);
    n_checks++; if (a_obs !== 8'b1110_0000) begin n_err++; $display("FAIL lu_x0 obs=%b exp=%b", a_obs, 8'b1110_0000); end
    to_drive();
    rd = 5; rs1 = 5; rs1_used = 0;
    @(negedge clk);
    n_checks++; if (a_obs !== 8'b1110_0000) begin n_err++; $display("FAIL lu_unused obs=%b exp=%b", a_obs, 8'b1110_0000); end
    to_drive();
    rs2 = 5; rs2_used = 1;
    @(negedge clk);
    n_checks++; if (b_obs !== 8'b0011_0010) begin n_err++; $display("FAIL lu_rs2 obs=%b exp=%b", b_obs, 8'b0011_0010); end
    to_drive();
    clear_inputs();
    @(negedge clk);
    n_checks++; if (a_sc !== 32'd2) begin n_err++; $display("FAIL lu_cnt2 obs=%0d exp=2", a_sc); end
    to_drive();
  endtask

  task automatic test_priority();
    apply_reset();
    br = 1; mem_rd = 1; rd = 5; rs1 = 5; rs1_used = 1;
    @(negedge clk);
    n_checks++; if (a_obs !== 8'b1110_0011) begin n_err++; $display("FAIL prio_br_lu obs=%b exp=%b", a_obs, 8'b1110_0011); end
    to_drive();
    clear_inputs();
    @(negedge clk);
    n_checks++; if (a_rc !== 32'd1 || a_sc !== 32'd0) begin n_err++; $display("FAIL prio_br_lu_cnt rc=%0d sc=%0d exp=1/0", a_rc, a_sc); end
    for (int k = 0; k < 4; k++) to_drive();
    br = 1; mem_rd = 1; rd = 5; rs1 = 5; rs1_used = 1; mdu = 1;
    @(negedge clk);
    n_checks++; if (a_obs !== 8'b1110_0011) begin n_err++; $display("FAIL prio_br_mdu obs=%b exp=%b", a_obs, 8'b1110_0011); end
    to_drive();
    clear_inputs();
    @(negedge clk);
    n_checks++; if (a_rc !== 32'd2 || a_sc !== 32'd0) begin n_err++; $display("FAIL prio_br_mdu_cnt rc=%0d sc=%0d exp=2/0", a_rc, a_sc); end
    to_drive();
  endtask

  task automatic test_mdu();
    apply_reset();
    mdu = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_checks++; if (a_obs !== 8'b0001_0000) begin n_err++; $display("FAIL mdu_c%0d obs=%b exp=%b", k, a_obs, 8'b0001_0000); end
      to_drive();
    end
    mdu = 0;
    @(negedge clk);
    n_checks++; if (a_sc !== 32'd4) begin n_err++; $display("FAIL mdu_cnt obs=%0d exp=4", a_sc); end
    to_drive();
  endtask

  task automatic test_rehold();
    logic [7:0] exp_b [7] = '{8'b1110_0111, 8'b1110_0001, 8'b1110_0111, 8'b1110_0001,
                              8'b1110_0001, 8'b1110_0001, 8'b1110_0000};
    apply_reset();
    for (int k = 0; k < 7; k++) begin
      br = (k == 0 || k == 2);
      @(negedge clk);
      n_checks++; if (b_obs !== exp_b[k]) begin n_err++; $display("FAIL rehold_t%0d obs=%b exp=%b", k, b_obs, exp_b[k]); end
      if (k == 3) begin
        n_checks++; if (b_rc !== 2'd2) begin n_err++; $display("FAIL rehold_rc obs=%0d exp=2", b_rc); end
      end
      to_drive();
    end
    br = 0;
  endtask

  task automatic test_saturate();
    apply_reset();
    mdu = 1;
    for (int k = 0; k < 5; k++) to_drive();
    mdu = 0;
    @(negedge clk);
    n_checks++; if (b_sc !== 2'd3) begin n_err++; $display("FAIL sat_b obs=%0d exp=3", b_sc); end
    n_checks++; if (a_sc !== 32'd5) begin n_err++; $display("FAIL sat_a obs=%0d exp=5", a_sc); end
    to_drive();
  endtask

  task automatic test_reset_mid_hold();
    apply_reset();
    br = 1;
    to_drive();
    br = 0; rst = 1;
    @(negedge clk);
    n_checks++; if (a_obs !== 8'b0000_0011) begin n_err++; $display("FAIL rst_hold_a obs=%b exp=%b", a_obs, 8'b0000_0011); end
    n_checks++; if (b_obs !== 8'b0000_0111) begin n_err++; $display("FAIL rst_hold_b obs=%b exp=%b", b_obs, 8'b0000_0111); end
    to_drive();
    rst = 0;
    @(negedge clk);
    n_checks++; if (a_obs !== 8'b1110_0000) begin n_err++; $display("FAIL rst_hold_release obs=%b exp=%b", a_obs, 8'b1110_0000); end
    to_drive();
  endtask

  task automatic test_random();
    logic [7:0] ea, eb;
    apply_reset();
    for (int k = 0; k < 400; k++) begin
      rst      = ($urandom_range(0, 49) == 0);
      br       = ($urandom_range(0, 9) == 0);
      mdu      = ($urandom_range(0, 4) == 0);
      mem_rd   = $urandom_range(0, 1);
      rs1_used = $urandom_range(0, 1);
      rs2_used = $urandom_range(0, 1);
      rs1      = 5'($urandom_range(0, 3));
      rs2      = 5'($urandom_range(0, 3));
      rd       = 5'($urandom_range(0, 3));
      @(negedge clk);
      ea = model_out(0);
      eb = model_out(1);
      n_checks++; if (a_obs !== ea) begin n_err++; $display("FAIL rand_ctrl_a c%0d obs=%b exp=%b", k, a_obs, ea); end
      n_checks++; if (b_obs !== eb) begin n_err++; $display("FAIL rand_ctrl_b c%0d obs=%b exp=%b", k, b_obs, eb); end
      n_checks++; if (a_rc !== 32'(m_rc[0]) || a_sc !== 32'(m_sc[0])) begin n_err++; $display("FAIL rand_cnt_a c%0d rc=%0d sc=%0d exp=%0d/%0d", k, a_rc, a_sc, m_rc[0], m_sc[0]); end
      n_checks++; if (b_rc !== 2'(m_rc[1]) || b_sc !== 2'(m_sc[1])) begin n_err++; $display("FAIL rand_cnt_b c%0d rc=%0d sc=%0d exp=%0d/%0d", k, b_rc, b_sc, m_rc[1], m_sc[1]); end
      to_drive();
    end
    rst = 0;
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_branch_hold();
    test_load_use();
    test_priority();
    test_mdu();
    test_rehold();
    test_saturate();
    test_reset_mid_hold();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Parametrised hazard and flush controller for the 5-stage RISC-V pipeline, generalising the single-wire branch flush into a per-stage flush vector. It resolves taken-branch redirects, load-use hazards and multi-cycle MDU stalls, and drives enables and flushes for the PC and the pipeline registers. It also holds the IF/ID flush for a configurable number of cycles after a redirect, so in-flight fetches are discarded, and keeps saturating redirect and stall counters for performance analysis.

## Interface
- NUM_FLUSH, 2, number of pipeline registers cleared on redirect; bit 0 = IF/ID, bit 1 = ID/EX, bit 2 = EX/MEM; legal range 2..4
- FLUSH_HOLD, 1, cycles IF/ID stays flushed per redirect, including the redirect cycle; minimum 1
- REG_ADDR_W, 5, register index width
- CNT_W, 32, width of the performance counters; minimum 2
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- branch_taken  in  1  taken branch/jump resolved this cycle; single-cycle pulse
- id_rs1, id_rs2  in  REG_ADDR_W each  source registers of the instruction in ID
- id_rs1_used, id_rs2_used  in  1 each  ID instruction reads rs1/rs2
- ex_rd  in  REG_ADDR_W  destination register of the instruction in EX
- ex_mem_read  in  1  instruction in EX is a load
- mdu_busy  in  1  multi-cycle mul/div unit is busy; freeze the front end
- pc_en  out  1  PC register update enable
- ifid_en  out  1  IF/ID register enable
- idex_en  out  1  ID/EX register enable
- flush_vec  out  NUM_FLUSH  per-register synchronous clear
- stall  out  1  load-use or MDU stall active this cycle
- redirect_cnt  out  CNT_W  count of accepted redirects, saturating
- stall_cnt  out  CNT_W  count of stall cycles, saturating

## Operation
- Load-use hazard: ex_mem_read AND ex_rd≠0 AND ((id_rs1_used AND id_rs1==ex_rd) OR (id_rs2_used AND id_rs2==ex_rd)).
- FSM states:
  - RUN
  - HOLD, with a down-counter hold_left of width $clog2(FLUSH_HOLD+1)
- Per-cycle decision, highest priority first:
  - rst: flush_vec all ones; pc_en, ifid_en and idex_en all 0; state RUN; hold_left 0; both counters 0.
  - branch_taken (any state): flush_vec all ones; pc_en, ifid_en and idex_en all 1; stall 0; redirect_cnt +1. If FLUSH_HOLD>1, next state is HOLD with hold_left=FLUSH_HOLD-1; otherwise the next state is RUN.
  - HOLD: flush_vec bit 0 only; all enables 1; stall 0. hold_left decrements; state returns to RUN on the cycle after hold_left is 1. Hazards are ignored, because ID holds a bubble.
  - mdu_busy: flush_vec 0; pc_en, ifid_en and idex_en all 0; stall 1; stall_cnt +1.
  - Load-use: pc_en 0; ifid_en 0; idex_en 1; flush_vec bit 1 only, which injects a bubble into ID/EX; stall 1; stall_cnt +1.
  - Otherwise: all enables 1; flush_vec 0; stall 0.
- A branch_taken in HOLD restarts the hold: hold_left reloads to FLUSH_HOLD-1 and redirect_cnt increments.
- Simultaneous events resolve strictly by the priority order above. The lower-priority event has no effect on any output or counter.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Counter increments are registered and visible the cycle after the event.

## Timing
- Control outputs are combinational from the inputs and the registered state, with zero latency: a flush or stall applies at the same clock edge as its cause.
- The FSM state, hold_left and the counters are registered.
- Reset values while rst is high:
  - flush_vec all ones
  - pc_en 0, ifid_en 0, idex_en 0
  - stall 0
  - redirect_cnt 0, stall_cnt 0
- First normal cycle after rst deasserts: all enables 1, flush_vec 0.
- A redirect occupies exactly FLUSH_HOLD cycles of IF/ID flush. Bits 1 and above of flush_vec are asserted in the branch cycle only.
- A load-use stall lasts one cycle if the inputs update normally. If the hazard condition persists, the stall persists.
- Reset asserted mid-HOLD aborts the hold, with RUN as the state after reset.

## Test plan
- FLUSH_HOLD=3, NUM_FLUSH=2, branch_taken pulse at cycle t:
  - t: flush_vec=2'b11
  - t+1, t+2: flush_vec=2'b01
  - t+3: flush_vec=2'b00
  - redirect_cnt=1 at t+1
- Load-use with ex_mem_read=1, ex_rd=5, id_rs1=5, id_rs1_used=1: pc_en=0, ifid_en=0, flush_vec=2'b10, stall=1; stall_cnt=1 on the next cycle. Repeat with ex_rd=0, or with id_rs1_used=0: no stall.
- branch_taken and load-use in the same cycle: flush_vec=2'b11, pc_en=1, stall=0; redirect_cnt +1; stall_cnt unchanged. Repeat with mdu_busy=1: same result.
- mdu_busy=1 for 4 cycles: all enables 0 and flush_vec=0 throughout; stall_cnt=4.
- FLUSH_HOLD=4, second branch_taken at the redirect cycle +2: the hold restarts, and IF/ID stays flushed through the second redirect cycle +3.
- CNT_W=2, 5 stall cycles: stall_cnt reaches 3 and holds.
- rst asserted during HOLD: flush_vec all ones and enables 0 while rst is high; RUN with flush_vec 0 after release.
